// File: rtl/tlul_pkg.sv
// TL-UL bus payload types shared by hosts, devices and the host arbiter.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_DBW = TL_DW / 8;

    // Host-to-device: A-channel request plus D-channel ready.
    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    // Device-to-host: D-channel response plus A-channel ready.
    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb.sv
// N-to-1 TL-UL host arbiter. Round-robin A-channel arbitration with
// valid-stability lock, host index tagged into the upper a_source bits,
// outstanding-transaction limit, and tag-based D-channel return routing.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   tl_h_i  - N host requests
//   tl_h_o  - N host responses
//   tl_d_o  - device request
//   tl_d_i  - device response
module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter int unsigned N              = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i [N],
    output tl_d2h_t tl_h_o [N],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned LowW = TL_AIW - IdxW;

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] cand;
    logic            found;
    logic            gate;
    logic            dn_a_valid;
    logic            dn_d_ready;
    logic            a_hs;
    logic            d_hs;
    logic [IdxW-1:0] d_idx;
    logic            d_hit;
    logic            unused_src_hi;

    // Grant selection: locked host, else first requester from ptr onward.
    always_comb begin : p_grant
        grant = ptr_q;
        found = 1'b0;
        cand  = '0;
        if (lock_q) begin
            grant = gidx_q;
            found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = IdxW'((32'(ptr_q) + k) % N);
                if (!found && tl_h_i[cand].a_valid) begin
                    found = 1'b1;
                    grant = cand;
                end
            end
        end
    end

    // The gate looks at registered cnt, so a D handshake reopens A one cycle later.
    assign gate       = (cnt_q == CntW'(MaxOutstanding));
    assign dn_a_valid = !gate && found && tl_h_i[grant].a_valid;
    assign a_hs       = dn_a_valid && tl_d_i.a_ready;

    // D-channel tag decode; tags beyond N are sunk.
    assign d_idx = tl_d_i.d_source[TL_AIW-1 -: IdxW];

    always_comb begin : p_d_hit
        d_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (d_idx == IdxW'(i)) begin
                d_hit = 1'b1;
            end
        end
    end

    assign dn_d_ready = d_hit ? tl_h_i[d_idx].d_ready : 1'b1;
    assign d_hs       = tl_d_i.d_valid && dn_d_ready;

    // Downstream request mux.
    always_comb begin : p_a_mux
        tl_d_o = '0;
        if (dn_a_valid) begin
            tl_d_o          = tl_h_i[grant];
            tl_d_o.a_source = {grant, tl_h_i[grant].a_source[LowW-1:0]};
        end
        tl_d_o.a_valid = dn_a_valid;
        tl_d_o.d_ready = dn_d_ready;
    end

    // Upstream response demux; non-selected hosts see all-zero D fields.
    always_comb begin : p_h_out
        for (int unsigned i = 0; i < N; i++) begin
            tl_h_o[IdxW'(i)] = '0;
            if (tl_d_i.d_valid && d_hit && (d_idx == IdxW'(i))) begin
                tl_h_o[IdxW'(i)]          = tl_d_i;
                tl_h_o[IdxW'(i)].d_source = {{IdxW{1'b0}}, tl_d_i.d_source[LowW-1:0]};
            end
            tl_h_o[IdxW'(i)].a_ready = dn_a_valid && (grant == IdxW'(i)) && tl_d_i.a_ready;
        end
    end

    // Upper host a_source bits are replaced by the tag.
    always_comb begin : p_unused
        unused_src_hi = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            unused_src_hi = unused_src_hi ^ (^tl_h_i[IdxW'(i)].a_source[TL_AIW-1 -: IdxW]);
        end
    end

    // Next state: lock tracks a stalled offer, ptr advances past the winner.
    always_comb begin : p_next
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        lock_d = dn_a_valid && !tl_d_i.a_ready;
        gidx_d = lock_d ? grant : gidx_q;
        if (a_hs) begin
            ptr_d = (grant == IdxW'(N - 1)) ? '0 : grant + IdxW'(1);
        end
        if (a_hs && !d_hs) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!a_hs && d_hs && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_regs
        if (!rst_ni) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            gidx_q <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            gidx_q <= gidx_d;
            cnt_q  <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is a protocol error upstream.
    always_ff @(posedge clk_i) begin : p_cnt_underflow
        if (rst_ni) begin
            assert (!(d_hs && !a_hs && (cnt_q == '0)))
                else $error("tlul_host_arb: D response with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_tlul_host_arb.sv
// Bench for tlul_host_arb: a 2-host instance checked every cycle against a
// behavioural model, plus a 3-host instance driven with directed vectors.
module tb_tlul_host_arb;
    import tlul_pkg::*;

    logic clk;
    logic rst_n;

    tl_h2d_t h2_i [2];
    tl_d2h_t h2_o [2];
    tl_h2d_t d2_o;
    tl_d2h_t d2_i;

    tl_h2d_t h3_i [3];
    tl_d2h_t h3_o [3];
    tl_h2d_t d3_o;
    tl_d2h_t d3_i;

    int n_pass;
    int n_total;
    bit auto_resp;

    int m_ptr, m_lock, m_cnt;
    int n_ptr, n_lock, n_cnt;
    bit n_valid;

    tlul_host_arb #(.N(2), .MaxOutstanding(2)) u_dut (
        .clk_i (clk), .rst_ni(rst_n),
        .tl_h_i(h2_i), .tl_h_o(h2_o), .tl_d_o(d2_o), .tl_d_i(d2_i)
    );

    tlul_host_arb #(.N(3), .MaxOutstanding(2)) u_dut3 (
        .clk_i (clk), .rst_ni(rst_n),
        .tl_h_i(h3_i), .tl_h_o(h3_o), .tl_d_o(d3_o), .tl_d_i(d3_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model of the 2-host/Max=2 instance: compares outputs and computes the next state.
    task automatic model_check();
        int g;
        bit gate, eav, ahs, dhs, exp_dr, exp_dv;
        int tag;
        g = -1;
        if (m_lock >= 0) g = m_lock;
        else begin
            for (int k = 0; k < 2; k++) begin
                int j;
                j = (m_ptr + k) % 2;
                if (g < 0 && h2_i[1'(j)].a_valid) g = j;
            end
        end
        gate = (m_cnt == 2);
        eav  = !gate && (g >= 0) && h2_i[1'(g)].a_valid;
        chk("m_a_valid", 64'(d2_o.a_valid), 64'(eav));
        if (eav) begin
            chk("m_a_source", 64'(d2_o.a_source), 64'(g * 128 + (h2_i[1'(g)].a_source & 8'h7f)));
            chk("m_a_address", 64'(d2_o.a_address), 64'(h2_i[1'(g)].a_address));
        end
        for (int i = 0; i < 2; i++) begin
            chk("m_a_ready", 64'(h2_o[1'(i)].a_ready), 64'((eav && g == i) ? d2_i.a_ready : 1'b0));
        end
        tag    = d2_i.d_source >> 7;
        exp_dr = h2_i[1'(tag)].d_ready;
        chk("m_d_ready", 64'(d2_o.d_ready), 64'(exp_dr));
        for (int i = 0; i < 2; i++) begin
            exp_dv = d2_i.d_valid && (tag == i);
            chk("m_d_valid", 64'(h2_o[1'(i)].d_valid), 64'(exp_dv));
            chk("m_d_data", 64'(h2_o[1'(i)].d_data), exp_dv ? 64'(d2_i.d_data) : 64'(0));
            if (exp_dv) chk("m_d_source", 64'(h2_o[1'(i)].d_source), 64'(d2_i.d_source & 8'h7f));
        end
        ahs = eav && d2_i.a_ready;
        dhs = d2_i.d_valid && exp_dr;
        n_cnt = m_cnt + (ahs ? 1 : 0) - (dhs ? 1 : 0);
        if (n_cnt < 0) n_cnt = 0;
        n_lock = (eav && !d2_i.a_ready) ? g : -1;
        n_ptr  = ahs ? (g + 1) % 2 : m_ptr;
    endtask

    // Compare process: check at the falling edge, commit at the rising edge.
    initial begin
        m_ptr = 0; m_lock = -1; m_cnt = 0;
        forever begin
            @(negedge clk);
            n_valid = 1'b0;
            if (!rst_n) begin
                m_ptr = 0; m_lock = -1; m_cnt = 0;
            end else begin
                model_check();
                n_valid = 1'b1;
            end
            @(posedge clk);
            if (!rst_n) begin
                m_ptr = 0; m_lock = -1; m_cnt = 0;
            end else if (n_valid) begin
                m_ptr = n_ptr; m_lock = n_lock; m_cnt = n_cnt;
            end
        end
    end

    task automatic settle();
        #3;
    endtask

    // Advance one cycle; optionally answer last cycle's handshake on the 2-host device.
    task automatic tick();
        bit p;
        logic [7:0] s;
        @(negedge clk);
        p = auto_resp && d2_o.a_valid && d2_i.a_ready;
        s = d2_o.a_source;
        @(posedge clk);
        #1;
        if (auto_resp) begin
            d2_i.d_valid  = p;
            d2_i.d_source = s;
            d2_i.d_data   = {24'h0, s} ^ 32'hA5A5_0000;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        auto_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            h2_i[1'(i)] = '0;
            h2_i[1'(i)].d_ready = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            h3_i[2'(i)] = '0;
            h3_i[2'(i)].d_ready = 1'b1;
        end
        d2_i = '0;
        d3_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_h2(input int i, input bit v, input logic [7:0] src, input logic [31:0] addr);
        h2_i[1'(i)].a_valid   = v;
        h2_i[1'(i)].a_source  = src;
        h2_i[1'(i)].a_address = addr;
        h2_i[1'(i)].a_data    = ~addr;
        h2_i[1'(i)].a_opcode  = 3'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        auto_resp = 1'b0;
        for (int i = 0; i < 2; i++) h2_i[1'(i)] = '0;
        for (int i = 0; i < 3; i++) h3_i[2'(i)] = '0;
        d2_i = '0;
        d3_i = '0;
        #2;
        chk("rst_a_valid", 64'(d2_o.a_valid), 64'(0));
        chk("rst_d_valid0", 64'(h2_o[0].d_valid), 64'(0));
        chk("rst_d_valid1", 64'(h2_o[1].d_valid), 64'(0));
        chk("rst_a_valid3", 64'(d3_o.a_valid), 64'(0));

        // Round-robin with both hosts requesting and immediate responses.
        do_reset();
        auto_resp = 1'b1;
        d2_i.a_ready = 1'b1;
        set_h2(0, 1'b1, 8'h11, 32'h1000);
        set_h2(1, 1'b1, 8'h22, 32'h2000);
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("rr_msb", 64'(d2_o.a_source[7]), 64'(c % 2));
            tick();
        end
        set_h2(0, 1'b0, 8'h11, 32'h1000);
        set_h2(1, 1'b0, 8'h22, 32'h2000);
        tick();
        tick();

        // Lock: stalled host0 is held even when host1 joins and ptr favours it.
        do_reset();
        auto_resp = 1'b1;
        d2_i.a_ready = 1'b1;
        set_h2(0, 1'b1, 8'h00, 32'hA0);
        tick();
        set_h2(0, 1'b1, 8'h01, 32'hA1);
        d2_i.a_ready = 1'b0;
        settle();
        chk("lock_c1_addr", 64'(d2_o.a_address), 64'(32'hA1));
        tick();
        set_h2(1, 1'b1, 8'h02, 32'hB0);
        for (int c = 2; c < 4; c++) begin
            settle();
            chk("lock_addr", 64'(d2_o.a_address), 64'(32'hA1));
            chk("lock_h1_ready", 64'(h2_o[1].a_ready), 64'(0));
            tick();
        end
        d2_i.a_ready = 1'b1;
        settle();
        chk("lock_hs_addr", 64'(d2_o.a_address), 64'(32'hA1));
        chk("lock_h0_ready", 64'(h2_o[0].a_ready), 64'(1));
        tick();
        settle();
        chk("lock_next_h1", 64'(d2_o.a_address), 64'(32'hB0));
        tick();
        set_h2(0, 1'b0, 8'h00, 32'h0);
        set_h2(1, 1'b0, 8'h00, 32'h0);
        tick();
        tick();

        // Outstanding limit of 2 with a silent device.
        do_reset();
        d2_i.a_ready = 1'b1;
        set_h2(0, 1'b1, 8'h03, 32'h300);
        set_h2(1, 1'b1, 8'h04, 32'h400);
        settle();
        chk("gate_c0_valid", 64'(d2_o.a_valid), 64'(1));
        tick();
        settle();
        chk("gate_c1_valid", 64'(d2_o.a_valid), 64'(1));
        tick();
        settle();
        chk("gate_c2_valid", 64'(d2_o.a_valid), 64'(0));
        chk("gate_c2_rdy0", 64'(h2_o[0].a_ready), 64'(0));
        chk("gate_c2_rdy1", 64'(h2_o[1].a_ready), 64'(0));
        tick();
        d2_i.d_valid  = 1'b1;
        d2_i.d_source = 8'h80;
        settle();
        chk("gate_d_cycle_valid", 64'(d2_o.a_valid), 64'(0));
        chk("gate_d_ready", 64'(d2_o.d_ready), 64'(1));
        tick();
        d2_i.d_valid = 1'b0;
        settle();
        chk("gate_reopen", 64'(d2_o.a_valid), 64'(1));
        tick();
        set_h2(0, 1'b0, 8'h0, 32'h0);
        set_h2(1, 1'b0, 8'h0, 32'h0);
        d2_i.d_valid  = 1'b1;
        d2_i.d_source = 8'h00;
        tick();
        tick();
        d2_i.d_valid = 1'b0;
        tick();

        // Source tagging and response routing.
        do_reset();
        d2_i.a_ready = 1'b1;
        set_h2(1, 1'b1, 8'h05, 32'h55);
        settle();
        chk("tag_a_source", 64'(d2_o.a_source), 64'(8'h85));
        tick();
        set_h2(1, 1'b0, 8'h05, 32'h55);
        h2_i[0].d_ready = 1'b0;
        h2_i[1].d_ready = 1'b0;
        d2_i.d_valid  = 1'b1;
        d2_i.d_source = 8'h85;
        d2_i.d_data   = 32'hDEAD_BEEF;
        settle();
        chk("route_stall_ready", 64'(d2_o.d_ready), 64'(0));
        chk("route_h1_valid", 64'(h2_o[1].d_valid), 64'(1));
        chk("route_h1_source", 64'(h2_o[1].d_source), 64'(8'h05));
        chk("route_h0_valid", 64'(h2_o[0].d_valid), 64'(0));
        tick();
        h2_i[1].d_ready = 1'b1;
        settle();
        chk("route_ready", 64'(d2_o.d_ready), 64'(1));
        chk("route_h1_data", 64'(h2_o[1].d_data), 64'(32'hDEAD_BEEF));
        tick();
        d2_i.d_valid = 1'b0;
        tick();

        // Simultaneous A and D handshakes at cnt=1 leave the count at 1.
        do_reset();
        d2_i.a_ready = 1'b1;
        set_h2(0, 1'b1, 8'h06, 32'h600);
        tick();
        set_h2(0, 1'b0, 8'h06, 32'h600);
        set_h2(1, 1'b1, 8'h07, 32'h700);
        d2_i.d_valid  = 1'b1;
        d2_i.d_source = 8'h00;
        tick();
        d2_i.d_valid = 1'b0;
        set_h2(1, 1'b0, 8'h07, 32'h700);
        set_h2(0, 1'b1, 8'h08, 32'h800);
        settle();
        chk("same_cyc_open", 64'(d2_o.a_valid), 64'(1));
        tick();
        settle();
        chk("same_cyc_gated", 64'(d2_o.a_valid), 64'(0));
        tick();
        set_h2(0, 1'b0, 8'h0, 32'h0);
        d2_i.d_valid  = 1'b1;
        d2_i.d_source = 8'h80;
        tick();
        tick();
        d2_i.d_valid = 1'b0;
        tick();

        // Asynchronous reset while host1 holds the lock.
        do_reset();
        d2_i.a_ready = 1'b1;
        set_h2(0, 1'b1, 8'h09, 32'h900);
        tick();
        set_h2(0, 1'b0, 8'h09, 32'h900);
        set_h2(1, 1'b1, 8'h03, 32'hA00);
        d2_i.a_ready = 1'b0;
        tick();
        set_h2(0, 1'b1, 8'h09, 32'h900);
        #1;
        chk("pre_rst_locked", 64'(d2_o.a_source[7]), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(d2_o.a_valid), 64'(1));
        chk("rst_async_ptr", 64'(d2_o.a_source[7]), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d2_i.a_ready = 1'b1;
        settle();
        chk("post_rst_c0", 64'(d2_o.a_source), 64'(8'h09));
        tick();
        settle();
        chk("post_rst_c1", 64'(d2_o.a_valid), 64'(1));
        tick();
        settle();
        chk("post_rst_c2_gated", 64'(d2_o.a_valid), 64'(0));
        tick();
        set_h2(0, 1'b0, 8'h0, 32'h0);
        set_h2(1, 1'b0, 8'h0, 32'h0);
        d2_i.d_valid  = 1'b1;
        d2_i.d_source = 8'h00;
        tick();
        tick();
        d2_i.d_valid = 1'b0;
        tick();

        // Three hosts: rotation, dropped out-of-range tag, routing to host2.
        do_reset();
        d3_i.a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h3_i[2'(i)].a_valid  = 1'b1;
            h3_i[2'(i)].a_source = 8'h01;
        end
        settle();
        chk("n3_grant0", 64'(d3_o.a_source), 64'(8'h01));
        tick();
        settle();
        chk("n3_grant1", 64'(d3_o.a_source), 64'(8'h41));
        tick();
        d3_i.d_valid  = 1'b1;
        d3_i.d_source = 8'hC0;
        for (int i = 0; i < 3; i++) h3_i[2'(i)].d_ready = 1'b0;
        settle();
        chk("n3_gated", 64'(d3_o.a_valid), 64'(0));
        chk("n3_drop_ready", 64'(d3_o.d_ready), 64'(1));
        chk("n3_drop_h0", 64'(h3_o[0].d_valid), 64'(0));
        chk("n3_drop_h1", 64'(h3_o[1].d_valid), 64'(0));
        chk("n3_drop_h2", 64'(h3_o[2].d_valid), 64'(0));
        tick();
        d3_i.d_valid = 1'b0;
        settle();
        chk("n3_reopen", 64'(d3_o.a_valid), 64'(1));
        chk("n3_grant2", 64'(d3_o.a_source), 64'(8'h81));
        tick();
        for (int i = 0; i < 3; i++) begin
            h3_i[2'(i)].a_valid = 1'b0;
            h3_i[2'(i)].d_ready = 1'b1;
        end
        d3_i.d_valid  = 1'b1;
        d3_i.d_source = 8'h81;
        settle();
        chk("n3_route_h2", 64'(h3_o[2].d_valid), 64'(1));
        chk("n3_route_src", 64'(h3_o[2].d_source), 64'(8'h01));
        chk("n3_route_h0", 64'(h3_o[0].d_valid), 64'(0));
        tick();
        tick();
        d3_i.d_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
